// File: rtl/out_port_pkg.sv
// Shared processor definitions used by the output port and its helpers.
package out_port_pkg;

    localparam int WORD_WIDTH = 16;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/out_port_ptr.sv
// Wrapping FIFO pointer; DEPTH is a power of two so natural overflow wraps it.
module out_port_ptr #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/out_port.sv
// Processor output port: buffers internal-bus writes in a small FIFO and
// presents them to an external consumer over a valid/ready handshake.
module out_port
    import out_port_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              bus_in,
    output logic                          busy,
    output logic                          ovf,
    input  logic                          clr_ovf,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop;
    logic             push;
    logic             drop;

    // Status outputs decode the registered count only; no input reaches them.
    assign out_valid = (count != '0);
    assign busy      = (count == FULL);
    assign out_data  = mem[rd_ptr];

    assign pop  = out_valid && out_ready;
    assign push = wr_en && (!busy || pop);
    assign drop = wr_en && busy && !pop;

    out_port_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_b (rst_b),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    out_port_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_b (rst_b),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // NOTE: storage is deliberately left out of reset; out_valid qualifies
    // out_data, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus_in;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (clr_ovf) begin
                ovf <= 1'b0;
            end else if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
